// File: rtl/cpu_fetch_pkg.sv
// Shared constants for the instruction fetch sequencer: instruction lengths,
// state encodings and the default reset-vector address.
package cpu_fetch_pkg;

  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;
  localparam logic [1:0] LEN_3 = 2'd3;

  localparam logic [2:0] FETCH_VEC0  = 3'd0;
  localparam logic [2:0] FETCH_VEC1  = 3'd1;
  localparam logic [2:0] FETCH_VEC2  = 3'd2;
  localparam logic [2:0] FETCH_FETCH = 3'd3;
  localparam logic [2:0] FETCH_DEC   = 3'd4;
  localparam logic [2:0] FETCH_OPL   = 3'd5;
  localparam logic [2:0] FETCH_OPH   = 3'd6;
  localparam logic [2:0] FETCH_HOLD  = 3'd7;

  localparam logic [15:0] RESET_VECTOR = 16'hFFFC;

endpackage

// File: rtl/cpu_oplen.sv
// Opcode length decoder (aaa_bbb_cc layout): purely combinational, 8-bit opcode in,
// byte count 1..3 out. cc=11 opcodes are undefined and treated as single-byte.
module cpu_oplen
  import cpu_fetch_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] len
);

  logic [2:0] bbb;
  logic [1:0] cc;

  assign bbb = opcode[4:2];
  assign cc  = opcode[1:0];

  always_comb begin
    len = LEN_1;
    case (cc)
      2'b01: len = (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? LEN_3 : LEN_2;
      2'b11: len = LEN_1;
      default: begin
        case (bbb)
          3'b011, 3'b111: len = LEN_3;
          3'b001, 3'b101: len = LEN_2;
          3'b000: begin
            if (opcode == 8'h20)  len = LEN_3;
            else if (opcode[7])   len = LEN_2;
            else                  len = LEN_1;
          end
          3'b100:  len = (cc == 2'b00) ? LEN_2 : LEN_1;
          default: len = LEN_1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch sequencer: reset vector, then opcode/operand fetch; bundle valid 2/3/4 cycles
// after FETCH for len 1/2/3, held stable until instr_ready. CPU_FETCH_PREFETCH_EN reads ahead in HOLD.
module cpu_fetch
  import cpu_fetch_pkg::*;
#(
  parameter logic [15:0] VECTOR_ADDR = RESET_VECTOR,
  parameter int          ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        ir,
  output logic [7:0]        op_lo,
  output logic [7:0]        op_hi,
  output logic [1:0]        instr_len,
  output logic [ADDR_W-1:0] instr_pc
);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [15:0] pc;
  logic [1:0]  rdata_len;
  logic        redir_ok;

  cpu_oplen u_oplen (
    .opcode (mem_rdata),
    .len    (rdata_len)
  );

  // Redirects are only honoured once the vector has been loaded.
  assign redir_ok    = redirect && (state >= FETCH_FETCH);
  assign instr_valid = (state == FETCH_HOLD);

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_addr  = pc;
    case (state)
      FETCH_VEC0: begin
        mem_rd    = 1'b1;
        mem_addr  = VECTOR_ADDR;
        state_nxt = FETCH_VEC1;
      end
      FETCH_VEC1: begin
        mem_rd    = 1'b1;
        mem_addr  = VECTOR_ADDR + 16'd1;
        state_nxt = FETCH_VEC2;
      end
      FETCH_VEC2: state_nxt = FETCH_FETCH;
      FETCH_FETCH: begin
        mem_rd    = 1'b1;
        mem_addr  = pc;
        state_nxt = FETCH_DEC;
      end
      FETCH_DEC: begin
        if (rdata_len != LEN_1) begin
          mem_rd    = 1'b1;
          mem_addr  = pc + 16'd1;
          state_nxt = FETCH_OPL;
        end else begin
          state_nxt = FETCH_HOLD;
        end
      end
      FETCH_OPL: begin
        if (instr_len == LEN_3) begin
          mem_rd    = 1'b1;
          mem_addr  = pc + 16'd2;
          state_nxt = FETCH_OPH;
        end else begin
          state_nxt = FETCH_HOLD;
        end
      end
      FETCH_OPH: state_nxt = FETCH_HOLD;
      default: begin
`ifdef CPU_FETCH_PREFETCH_EN
        // Speculatively read the next opcode so acceptance can go straight to DEC.
        mem_rd   = 1'b1;
        mem_addr = pc + {14'd0, instr_len};
        if (instr_ready) state_nxt = FETCH_DEC;
`else
        if (instr_ready) state_nxt = FETCH_FETCH;
`endif
      end
    endcase
    if (redir_ok) begin
      state_nxt = FETCH_FETCH;
      mem_rd    = 1'b0;
    end
    if (rst) begin
      mem_rd   = 1'b0;
      mem_addr = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH_VEC0;
      pc        <= '0;
      ir        <= '0;
      op_lo     <= '0;
      op_hi     <= '0;
      instr_len <= LEN_1;
      instr_pc  <= '0;
    end else begin
      state <= state_nxt;
      if (redir_ok) begin
        pc <= redirect_pc;
      end else begin
        case (state)
          FETCH_VEC1: pc[7:0]  <= mem_rdata;
          FETCH_VEC2: pc[15:8] <= mem_rdata;
          FETCH_DEC: begin
            ir        <= mem_rdata;
            instr_pc  <= pc;
            instr_len <= rdata_len;
            op_lo     <= '0;
            op_hi     <= '0;
          end
          FETCH_OPL: op_lo <= mem_rdata;
          FETCH_OPH: op_hi <= mem_rdata;
          FETCH_HOLD: if (instr_ready) pc <= pc + {14'd0, instr_len};
          default: ;
        endcase
      end
    end
  end

endmodule
